// File: rtl/countdown_pkg.sv
// countdown_pkg: shared types and limits for the mm:ss countdown timer.
//   state_e  FSM encoding (IDLE, RUN, PAUSED, DONE)
//   SEC_W/MIN_W  field widths; SEC_MAX/MIN_MAX  largest seconds/minutes values
package countdown_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;
  localparam int SEC_W = 6;
  localparam int MIN_W = 7;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 7'd99;
endpackage

// File: rtl/countdown_if.sv
// countdown_if: control and status bundle of the countdown timer.
//   master: drives tick/clear/load/load_min/load_sec/start/pause, observes status
//   slave:  the timer; drives minutes/seconds/running/done/expired/load_err
interface countdown_if;
  import countdown_pkg::*;
  logic             tick;
  logic             clear;
  logic             load;
  logic [MIN_W-1:0] load_min;
  logic [SEC_W-1:0] load_sec;
  logic             start;
  logic             pause;
  logic [MIN_W-1:0] minutes;
  logic [SEC_W-1:0] seconds;
  logic             running;
  logic             done;
  logic             expired;
  logic             load_err;
  modport master (
    output tick, clear, load, load_min, load_sec, start, pause,
    input  minutes, seconds, running, done, expired, load_err
  );
  modport slave (
    input  tick, clear, load, load_min, load_sec, start, pause,
    output minutes, seconds, running, done, expired, load_err
  );
endinterface

// File: rtl/mod_down_counter.sv
// mod_down_counter: modulo-(MAX+1) down counter with clear, load and borrow-out.
//   clk, rst_n   clock, asynchronous active-low reset
//   clr_i        force to zero (highest priority)
//   ld_i/ld_val_i load a value
//   en_i         count down one step; wraps 0 -> MAX
//   cnt_o        current count (registered)
//   borrow_o     high when an enabled step wraps, to enable the next digit
module mod_down_counter #(
  parameter int           W   = 6,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         borrow_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr_i ? '0 : ld_i ? ld_val_i :
            en_i  ? ((cnt_q == '0) ? MAX : cnt_q - 1'b1) : cnt_q;
    borrow_o = en_i && (cnt_q == '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable mm:ss countdown with start/pause/clear FSM.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         countdown_if.slave: controls in, registered value/status out
module countdown_timer
  import countdown_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  countdown_if.slave bus
);
  state_e           state_q;
  logic             running_q, done_q, expired_q, load_err_q;
  logic [MIN_W-1:0] min_q;
  logic [SEC_W-1:0] sec_q;
  logic             load_ok, in_run, is_zero, tick_en, cnt_ld, expire;
  logic             sec_borrow, min_borrow;
  always_comb begin
    load_ok = (bus.load_min <= MIN_MAX) && (bus.load_sec <= SEC_MAX);
    in_run  = (state_q == RUN);
    is_zero = (min_q == '0) && (sec_q == '0);
    // any asserted control input masks the tick for this cycle
    tick_en = in_run && bus.tick && !bus.clear && !bus.load && !bus.start && !bus.pause;
    cnt_ld  = !bus.clear && bus.load && !in_run && load_ok;
    expire  = tick_en && (min_q == '0) && (sec_q == 6'd1);
  end
  mod_down_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (bus.clear),
    .ld_i     (cnt_ld),
    .ld_val_i (bus.load_sec),
    .en_i     (tick_en),
    .cnt_o    (sec_q),
    .borrow_o (sec_borrow)
  );
  mod_down_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (bus.clear),
    .ld_i     (cnt_ld),
    .ld_val_i (bus.load_min),
    .en_i     (sec_borrow),
    .cnt_o    (min_q),
    .borrow_o (min_borrow)
  );
  // RUN is never entered or kept at 00:00, so minutes can never wrap
  assert property (@(posedge clk) disable iff (!rst_n) !min_borrow);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      expired_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      expired_q  <= 1'b0;
      load_err_q <= 1'b0;
      if (bus.clear) begin
        state_q   <= IDLE;
        running_q <= 1'b0;
        done_q    <= 1'b0;
      end else if (bus.load) begin
        if (!in_run) begin
          if (load_ok) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
          end else load_err_q <= 1'b1;
        end
      end else if (bus.start) begin
        if ((state_q == IDLE || state_q == PAUSED) && !is_zero) begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
      end else if (bus.pause) begin
        if (in_run) begin
          state_q   <= PAUSED;
          running_q <= 1'b0;
        end
      end else if (expire) begin
        state_q   <= DONE;
        running_q <= 1'b0;
        done_q    <= 1'b1;
        expired_q <= 1'b1;
      end
    end
  assign bus.minutes  = min_q;
  assign bus.seconds  = sec_q;
  assign bus.running  = running_q;
  assign bus.done     = done_q;
  assign bus.expired  = expired_q;
  assign bus.load_err = load_err_q;
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable mm:ss countdown timer and the down-counting counterpart of the team's up-counting seconds counter.
- Decrements once per 1 Hz tick from a loaded value to 00:00.
- Start/pause/clear control via a small FSM.
- Raises a one-cycle expired pulse and a sticky done level on reaching 00:00.
- Sits beside the clock-keeping counters and shares their tick source.

Parameters:
MIN_MAX, 99, largest loadable minutes value; minutes width 7 bits.
SEC_MAX, 59, largest seconds value; seconds reload value on borrow.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
tick  in  1  one-cycle 1 Hz enable pulse
clear  in  1  return to IDLE, value 00:00
load  in  1  load load_min/load_sec (IDLE, PAUSED or DONE only)
load_min  in  7  minutes to load
load_sec  in  6  seconds to load
start  in  1  begin or resume counting
pause  in  1  suspend counting
minutes  out  7  current minutes
seconds  out  6  current seconds
running  out  1  high in RUN
done  out  1  high in DONE
expired  out  1  one-cycle pulse on entry to DONE
load_err  out  1  one-cycle pulse on a rejected load

Behaviour:
- Reset state: IDLE, minutes=0, seconds=0, running=0, done=0, expired=0, load_err=0.
- All outputs are registered. Pulse outputs default to 0 every cycle.
- Control priority within one cycle: clear > load > start > pause > tick.
  - Lower-priority inputs are ignored in that cycle.
  - Exception: tick is still applied in RUN when no higher control input is asserted.
- clear: from any state, next state IDLE, value 00:00, done=0.
- load:
  - Accepted in IDLE, PAUSED or DONE. Ignored in RUN, with no error.
  - Valid when load_min<=MIN_MAX and load_sec<=SEC_MAX.
  - Valid load: value updates next edge. State becomes IDLE (from DONE also clears done).
  - Invalid load: value unchanged, load_err=1 for one cycle, state unchanged.
- start:
  - IDLE or PAUSED with value != 00:00: go to RUN.
  - Value == 00:00 or state DONE: ignored.
- pause: RUN to PAUSED. Ignored in other states.
- tick in RUN:
  - seconds>0: seconds-1.
  - seconds==0 and minutes>0: seconds=SEC_MAX, minutes-1.
- Expiry: a tick in RUN at value 00:01 sets value 00:00, state DONE, done=1 and expired=1 on the same edge.
  - expired drops the following cycle. done holds until clear or a valid load.
- tick outside RUN: no effect. No underflow below 00:00 is possible.
- running = (state==RUN). Update it on the same edge as the state.
- Simultaneous pause and tick in RUN: pause wins and the value is not decremented.
- Asynchronous reset mid-count: immediately forces the reset state. No pulse is emitted.

Decomposition:
- Package countdown_pkg:
  - state encoding IDLE=2'd0, RUN=2'd1, PAUSED=2'd2, DONE=2'd3
  - SEC_MAX, MIN_MAX and widths SEC_W=6, MIN_W=7
- One natural sub-module, mod_down_counter:
  - Parameterised modulus, with enable, load, borrow-out.
  - Instantiated twice: seconds, with borrow enabling minutes.
- The FSM lives in the top level.

Test Plan:
- Reset then load 01:05, start, apply 5 ticks -> 01:00, running=1, done=0. Next tick -> 00:59, minutes 1->0.
- Load 00:02, start, apply 2 ticks -> 00:00, done=1, expired high exactly one cycle, running=0. Further ticks leave 00:00.
- Load 00:10, start, 3 ticks, pause, 4 ticks, start, 1 tick -> 00:06. pause with tick in the same cycle -> no decrement.
- Load with load_sec=60 or load_min=100 -> load_err one-cycle pulse, value unchanged. load while RUN -> ignored, no load_err.
- In DONE apply start -> stays DONE. Then clear -> IDLE 00:00, done=0. Start at 00:00 -> stays IDLE.
- Load 99:59, start, then assert rst_n low mid-count asynchronously -> outputs 00:00, IDLE, no expired pulse.
